stream_vector_assembler: RTL

Upstream feeder for the streaming register file. Accepts one tile-wide element per beat from a functional-unit result port over a valid/ready handshake. Assembles a full slice vector of NUM_TILES_PER_SLICE elements in tile order, then issues a single-cycle write (enable, stream ID, full vector) toward the streaming register file. Also detects short vectors and stream-ID inconsistencies within a vector.

---
 rtl/stream_vector_assembler.sv | 87 ++++++++
 1 files changed

// File: rtl/stream_vector_assembler.sv
// stream_vector_assembler: gathers one element per beat into a slice vector and commits it to the SRF.
// Define STREAM_ASM_ZERO_FILL_EN to zero the unreceived tiles of a short vector.
module stream_vector_assembler #(
    parameter int NUM_STREAM_ID       = 5,
    parameter int MIN_VEC_LENGTH      = 16,
    parameter int NUM_TILES_PER_SLICE = 20
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic [MIN_VEC_LENGTH-1:0]                            in_data,
    input  logic [NUM_STREAM_ID-1:0]                             in_stream_id,
    input  logic                                                 in_last,
    output logic                                                 srf_write_enable,
    output logic [NUM_STREAM_ID-1:0]                             stream_id,
    output logic [0:NUM_TILES_PER_SLICE-1][MIN_VEC_LENGTH-1:0]   write_data,
    output logic                                                 busy,
    output logic                                                 short_vec,
    output logic                                                 id_mismatch
);
    localparam int CW = $clog2(NUM_TILES_PER_SLICE + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_TILES_PER_SLICE - 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_TILES_PER_SLICE);

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [NUM_STREAM_ID-1:0] id_q, id_n;
    logic [0:NUM_TILES_PER_SLICE-1][MIN_VEC_LENGTH-1:0] tiles, tiles_n, fill;
    logic accept, mismatch;

    always_comb begin
        accept   = in_valid && in_ready;
        state_n  = state;
        cnt_n    = cnt;
        id_n     = id_q;
        tiles_n  = tiles;
        mismatch = accept && state == COLLECT && in_stream_id != id_q;
        // cnt is zero in IDLE, so the same write path serves the first beat
        if (state == COMMIT) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (accept) begin
            tiles_n[cnt] = in_data;
            cnt_n        = cnt + 1'b1;
            id_n         = state == IDLE ? in_stream_id : id_q;
            state_n      = (in_last || cnt == LAST) ? COMMIT : COLLECT;
        end
        fill = tiles_n;
`ifdef STREAM_ASM_ZERO_FILL_EN
        for (int i = 0; i < NUM_TILES_PER_SLICE; i++)
            if (i >= int'(cnt_n)) fill[i] = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            id_q             <= '0;
            tiles            <= '0;
            in_ready         <= 1'b0;
            busy             <= 1'b0;
            srf_write_enable <= 1'b0;
            short_vec        <= 1'b0;
            id_mismatch      <= 1'b0;
            stream_id        <= '0;
            write_data       <= '0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            id_q             <= id_n;
            tiles            <= tiles_n;
            in_ready         <= state_n != COMMIT;
            busy             <= state_n != IDLE;
            srf_write_enable <= state_n == COMMIT;
            short_vec        <= state_n == COMMIT && cnt_n != FULL;
            id_mismatch      <= mismatch;
            if (state_n == COMMIT) begin
                stream_id  <= id_n;
                write_data <= fill;
            end
        end
    end
endmodule
